// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared definitions for the counter burst sequencer: the FSM state encoding
// and the default widths of the cycle-count and burst-count fields.
// Ports: none (package).
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned REP_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DELAY = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/load_down_counter.sv
// -----------------------------------------------------------------------------
// load_down_counter
// LEN_W-bit loadable down-counter with a zero flag. A load takes priority
// over counting; the count holds at zero instead of wrapping.
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    asynchronous active-low reset
//   i_load     load i_load_val this cycle
//   i_load_val value to load
//   o_zero     high while the count is zero
// -----------------------------------------------------------------------------
module load_down_counter
  import counter_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_val,
  output logic             o_zero
);

  localparam logic [LEN_W-1:0] ZERO_L = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] ONE_L  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [LEN_W-1:0] r_count;

  // Count register: load, decrement toward zero, or hold at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= ZERO_L;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != ZERO_L) begin
      r_count <= r_count - ONE_L;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == ZERO_L);

endmodule

// File: rtl/counter_burst_ctrl.sv
// -----------------------------------------------------------------------------
// counter_burst_ctrl
// Sequencer for a counter's enable/clear: on start it pulses clear, then runs
// (cfg_repeat+1) bursts of [cfg_delay idle cycles, cfg_len enable cycles],
// then pulses done. stop aborts any active sequence with an aborted pulse.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, stop           start request (IDLE only), abort request
//   cfg_delay/len/repeat  sequence configuration, latched on start
//   cnt_enable, cnt_clear controls to the counter
//   busy, burst_idx       status: active flag, 0-based burst number
//   done, aborted         one-cycle completion / abort pulses
// -----------------------------------------------------------------------------
module counter_burst_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_delay,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [REP_W-1:0] cfg_repeat,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             busy,
  output logic [REP_W-1:0] burst_idx,
  output logic             done,
  output logic             aborted
);

  localparam logic [LEN_W-1:0] ZERO_L = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] ONE_L  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] ZERO_R = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] ONE_R  = {{(REP_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [LEN_W-1:0] r_delay;
  logic [LEN_W-1:0] r_len;
  logic [REP_W-1:0] r_repeat;
  logic [REP_W-1:0] r_burst_idx;
  logic             r_cnt_enable;
  logic             r_cnt_clear;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  state_e           w_state_nxt;
  logic [REP_W-1:0] w_idx_nxt;
  logic             w_latch;
  logic             w_abort;
  logic             w_burst_end;
  logic             w_load;
  logic [LEN_W-1:0] w_load_val;
  logic             w_zero;

  // One shared down-counter times whichever phase (DELAY or RUN) is active.
  load_down_counter #(.LEN_W(LEN_W)) u_phase_cnt (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Next-state, burst index and phase-counter load decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_burst_idx;
    w_latch     = 1'b0;
    w_abort     = 1'b0;
    w_burst_end = 1'b0;
    w_load      = 1'b0;
    w_load_val  = ZERO_L;

    if ((r_state != IDLE) && stop) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = ZERO_R;
      w_abort     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          // stop beats start; with nothing running there is no abort pulse
          if (start && !stop) begin
            w_latch     = 1'b1;
            w_state_nxt = CLEAR;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        CLEAR: begin
          if (r_delay != ZERO_L) begin
            w_state_nxt = DELAY;
            w_load      = 1'b1;
            w_load_val  = r_delay - ONE_L;
          end else if (r_len != ZERO_L) begin
            w_state_nxt = RUN;
            w_load      = 1'b1;
            w_load_val  = r_len - ONE_L;
          end else begin
            // zero delay and zero length: every burst is empty
            w_state_nxt = DONE;
          end
        end
        DELAY: begin
          if (!w_zero) begin
            w_state_nxt = DELAY;
          end else if (r_len != ZERO_L) begin
            w_state_nxt = RUN;
            w_load      = 1'b1;
            w_load_val  = r_len - ONE_L;
          end else begin
            w_burst_end = 1'b1;
          end
        end
        RUN: begin
          if (!w_zero) begin
            w_state_nxt = RUN;
          end else begin
            w_burst_end = 1'b1;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = ZERO_R;
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = ZERO_R;
        end
      endcase

      // A burst end reached with delay=0 always comes from RUN, so len>0
      // here and re-entering RUN cannot produce an empty burst loop.
      if (w_burst_end) begin
        if (r_burst_idx < r_repeat) begin
          w_idx_nxt = r_burst_idx + ONE_R;
          w_load    = 1'b1;
          if (r_delay != ZERO_L) begin
            w_state_nxt = DELAY;
            w_load_val  = r_delay - ONE_L;
          end else begin
            w_state_nxt = RUN;
            w_load_val  = r_len - ONE_L;
          end
        end else begin
          w_state_nxt = DONE;
        end
      end else begin
        w_idx_nxt = w_idx_nxt;
      end
    end
  end

  // State, latched config and outputs, all decoded from the next state so
  // each output is aligned with the state it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_delay      <= ZERO_L;
      r_len        <= ZERO_L;
      r_repeat     <= ZERO_R;
      r_burst_idx  <= ZERO_R;
      r_cnt_enable <= 1'b0;
      r_cnt_clear  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_idx <= w_idx_nxt;
      if (w_latch) begin
        r_delay  <= cfg_delay;
        r_len    <= cfg_len;
        r_repeat <= cfg_repeat;
      end else begin
        r_delay  <= r_delay;
        r_len    <= r_len;
        r_repeat <= r_repeat;
      end
      r_cnt_enable <= (w_state_nxt == RUN);
      r_cnt_clear  <= (w_state_nxt == CLEAR);
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= (w_state_nxt == DONE);
      r_aborted    <= w_abort;
    end
  end

  assign cnt_enable = r_cnt_enable;
  assign cnt_clear  = r_cnt_clear;
  assign busy       = r_busy;
  assign burst_idx  = r_burst_idx;
  assign done       = r_done;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_counter_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_burst_ctrl
// Self-checking bench for counter_burst_ctrl. Expected waveforms come from a
// closed-form timeline: with p = delay+len, the clear is in cycle 1 after the
// start edge, burst b occupies cycles 2+b*p .. 1+(b+1)*p (delay then enable),
// and done is in cycle T = 2+(repeat+1)*p.
// -----------------------------------------------------------------------------
module tb_counter_burst_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [7:0] cfg_delay;
  logic [7:0] cfg_len;
  logic [3:0] cfg_repeat;
  logic       cnt_enable;
  logic       cnt_clear;
  logic       busy;
  logic [3:0] burst_idx;
  logic       done;
  logic       aborted;

  int n_err = 0;
  int n_chk = 0;
  logic [15:0] tb_cnt;

  counter_burst_ctrl #(.LEN_W(8), .REP_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .cfg_delay  (cfg_delay),
    .cfg_len    (cfg_len),
    .cfg_repeat (cfg_repeat),
    .cnt_enable (cnt_enable),
    .cnt_clear  (cnt_clear),
    .busy       (busy),
    .burst_idx  (burst_idx),
    .done       (done),
    .aborted    (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the controlled counter: clear wins over enable.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        tb_cnt <= 16'd0;
    else if (cnt_clear)  tb_cnt <= 16'd0;
    else if (cnt_enable) tb_cnt <= tb_cnt + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outs(input string tag, input logic en, input logic clr, input logic bsy,
                          input logic dn, input logic ab, input int idx);
    chk({tag, ".cnt_enable"}, {31'd0, cnt_enable}, {31'd0, en});
    chk({tag, ".cnt_clear"},  {31'd0, cnt_clear},  {31'd0, clr});
    chk({tag, ".busy"},       {31'd0, busy},       {31'd0, bsy});
    chk({tag, ".done"},       {31'd0, done},       {31'd0, dn});
    chk({tag, ".aborted"},    {31'd0, aborted},    {31'd0, ab});
    chk({tag, ".burst_idx"},  {28'd0, burst_idx},  idx);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one sequence; stop_k>0 raises stop during cycle stop_k (1..T).
  // noise scrambles config after latching and toggles start while busy.
  task automatic run_seq(input string tag, input int d, input int l, input int rep,
                         input int stop_k, input bit noise);
    int per;
    int t_done;
    int k_end;
    int idx;
    logic en;
    per    = d + l;
    t_done = 2 + (rep + 1) * per;
    k_end  = (stop_k > 0) ? stop_k : t_done;
    cfg_delay  = d[7:0];
    cfg_len    = l[7:0];
    cfg_repeat = rep[3:0];
    start = 1'b1;
    stop  = 1'b0;
    step();
    start = 1'b0;
    if (noise) begin
      cfg_delay  = 8'($urandom);
      cfg_len    = 8'($urandom);
      cfg_repeat = 4'($urandom);
    end
    for (int k = 1; k <= k_end; k++) begin
      en  = (k >= 2) && (k < t_done) && (((k - 2) % per) >= d);
      idx = (k >= 2) ? (((k - 2) / per > rep) ? rep : (k - 2) / per) : 0;
      chk_outs(tag, en, k == 1, 1'b1, k == t_done, 1'b0, idx);
      start = (noise && k < k_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop  = (k == stop_k);
      step();
    end
    start = 1'b0;
    stop  = 1'b0;
    if (stop_k > 0) begin
      chk_outs({tag, ".abort"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    end else begin
      chk_outs({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk({tag, ".count"}, {16'd0, tb_cnt}, l * (rep + 1));
    end
    step();
    chk_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int d;
    int l;
    int rep;
    int t_done;
    int sk;
    reset_n    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    cfg_delay  = 8'd0;
    cfg_len    = 8'd0;
    cfg_repeat = 4'd0;
    step();
    step();
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    run_seq("d3l5r0", 3, 5, 0, 0, 1'b0);
    run_seq("d0l4r2", 0, 4, 2, 0, 1'b0);
    run_seq("d2l3r1", 2, 3, 1, 0, 1'b0);
    run_seq("stop_run2", 1, 6, 0, 4, 1'b0);
    run_seq("d2l0r0", 2, 0, 0, 0, 1'b0);
    run_seq("busy_start", 2, 3, 1, 0, 1'b1);
    run_seq("max_delay", 255, 1, 0, 0, 1'b0);
    run_seq("max_len", 0, 255, 0, 0, 1'b0);
    run_seq("stop_clear", 2, 2, 1, 1, 1'b0);

    // start and stop together while idle: nothing happens
    cfg_delay  = 8'd1;
    cfg_len    = 8'd2;
    cfg_repeat = 4'd0;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk_outs("start_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step();
    chk_outs("start_stop2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // reset mid-RUN: outputs drop without waiting for a clock edge
    cfg_delay  = 8'd3;
    cfg_len    = 8'd5;
    cfg_repeat = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 6; k++) step();
    chk("mid_run.cnt_enable", {31'd0, cnt_enable}, 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step();
    chk_outs("async_reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_seq("after_reset", 1, 3, 1, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      d   = $urandom_range(0, 4);
      l   = $urandom_range(0, 5);
      if (d == 0 && l == 0) l = 1;
      rep = $urandom_range(0, 3);
      t_done = 2 + (rep + 1) * (d + l);
      sk  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, t_done) : 0;
      run_seq($sformatf("rnd%0d", i), d, l, rep, sk, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_burst_ctrl.md
Name: counter_burst_ctrl

Overview:
- Sequencer that drives the enable and synchronous-clear inputs of the team's counter blocks (n-bit counter, ripple counter with enable).
- On a start command it clears the counter, waits a programmable delay, then asserts enable for a programmable number of cycles, repeating for a programmable burst count.
- Sits between a configuration/stimulus source and one counter instance; replaces hand-timed enable waveforms in benches and top levels.

Parameters:
- LEN_W, 8, width of cfg_delay and cfg_len (cycle counts).
- REP_W, 4, width of cfg_repeat (extra bursts after the first).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled start request; acted on only in IDLE.
- stop  input  1  abort request; acted on in any non-IDLE state.
- cfg_delay  input  LEN_W  idle cycles before each burst.
- cfg_len  input  LEN_W  enable-high cycles per burst.
- cfg_repeat  input  REP_W  additional bursts after the first (total = cfg_repeat+1).
- cnt_enable  output  1  enable to the controlled counter.
- cnt_clear  output  1  one-cycle clear pulse to the controlled counter.
- busy  output  1  high whenever state != IDLE.
- burst_idx  output  REP_W  index of the current burst, 0-based.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse when stop terminates a sequence.

Behaviour:
- All outputs are registered. Reset (reset_n=0, asynchronous) forces state=IDLE and all outputs to 0, and clears internal counters and latched config.
- States: IDLE, CLEAR, DELAY, RUN, DONE.
- IDLE: start=1 and stop=0 at edge E latches cfg_delay/cfg_len/cfg_repeat and moves to CLEAR. Config inputs are ignored after latching. If start and stop are both 1, stop wins and start is ignored; no aborted pulse is issued because nothing is running.
- CLEAR: lasts exactly 1 cycle with cnt_clear=1 (the cycle after E). Next state is DELAY if latched delay>0, else RUN.
- DELAY: lasts exactly latched delay cycles with cnt_enable=0, then moves to RUN.
- RUN: cnt_enable=1 for exactly latched len cycles.
  - len=0: RUN is skipped (0 cycles, no enable) and completion logic applies as if the burst ended.
- End of burst: if burst_idx < latched repeat, increment burst_idx and go to DELAY (or RUN if delay=0). No cnt_clear between bursts, so the counter accumulates. Otherwise go to DONE.
- DONE: 1 cycle with done=1 and busy=1, then IDLE with burst_idx=0.
- Back-to-back bursts with delay=0: cnt_enable stays continuously high across the burst boundary, with no gap cycle.
- Timing check: with delay=d, len=L and repeat=0, cnt_enable is high in cycles E+2+d .. E+1+d+L and done is high in cycle E+2+d+L.
- stop=1 in CLEAR/DELAY/RUN/DONE: the next state is IDLE. In that next cycle cnt_enable=0, cnt_clear=0, busy=0, aborted=1 and burst_idx=0. done is not issued.
- start while busy is ignored and not queued.
- Down-counters for delay/len are LEN_W bits and load latched value-1. There is no wrap: maximum delay and len are 2^LEN_W-1 cycles.
- Reset asserted mid-sequence drops cnt_enable immediately (asynchronous) and issues no done or aborted pulse.

Decomposition:
- Shared package counter_ctrl_pkg holds the state enum (IDLE, CLEAR, DELAY, RUN, DONE) and default LEN_W/REP_W constants.
- One natural sub-module: load_down_counter, a LEN_W-bit loadable down-counter with a zero flag. It is reused for the delay and len phases.
- The FSM and burst counter stay in the top module.

Test Plan:
- Reset, then start with delay=3, len=5, repeat=0 -> cnt_clear high 1 cycle; cnt_enable high exactly 5 cycles, starting 4 cycles after the clear; done pulse 1 cycle later. A ripple counter wired to the outputs reads 5.
- delay=0, len=4, repeat=2 -> cnt_enable high for 12 consecutive cycles; burst_idx steps 0,1,2; single done; counter reads 12.
- delay=2, len=3, repeat=1 -> enable pattern 3 high, 2 low, 3 high; one cnt_clear only, at the start.
- stop asserted on the 2nd RUN cycle of delay=1, len=6 -> cnt_enable low the following cycle; aborted pulse; no done; busy=0.
- len=0, delay=2 -> cnt_enable never high; done pulse 4 cycles after start is sampled.
- Start pulse during busy, and start+stop together in IDLE -> no effect, no pulses. reset_n dropped mid-RUN -> all outputs 0 asynchronously; a subsequent start sequences normally.
